// File: rtl/apb_cmd_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : apb_cmd_master_if                                          |
// | Brief   : Command/response handshake plus APB4 requester bus bundle  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface apb_cmd_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output paddr, psel, penable, pwrite, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  paddr, psel, penable, pwrite, pwdata, pstrb
  );
endinterface
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : apb_cmd_master                                             |
// | Brief   : Single-transfer APB4 requester with wait-state watchdog    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module apb_cmd_master #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 255,
  parameter int TO_CNT_W = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  apb_cmd_master_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam bit c_TO_EN = (TIMEOUT != 0);
  localparam logic [TO_CNT_W-1:0] c_TO_LAST = TO_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_strb;
  logic [TO_CNT_W-1:0] r_wait_cnt;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_timeout;

  logic w_accept;
  logic w_abort;
  logic w_psel;
  logic w_penable;
  logic w_cmd_ready;
  logic w_rsp_valid;

  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);
  // Only meaningful in ACCESS; pready always wins over the watchdog.
  assign w_abort  = c_TO_EN && !bus.pready && (r_wait_cnt == c_TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) w_next = S_SETUP;
      end
      S_SETUP: begin
        w_psel = 1'b1;
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (bus.pready || w_abort) w_next = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Read transfers drive zero data and strobes so the slave never sees stale write bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_strb     <= '0;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= bus.cmd_addr;
      r_write    <= bus.cmd_write;
      r_wdata    <= bus.cmd_write ? bus.cmd_wdata : '0;
      r_strb     <= bus.cmd_write ? bus.cmd_strb : '0;
      r_wait_cnt <= '0;
    end else if (r_state == S_ACCESS) begin
      if (bus.pready) begin
        r_rdata   <= r_write ? '0 : bus.prdata;
        r_err     <= bus.pslverr;
        r_timeout <= 1'b0;
      end else if (w_abort) begin
        r_rdata   <= '0;
        r_err     <= 1'b1;
        r_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= r_wait_cnt + TO_CNT_W'(1);
      end
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.rsp_valid   = w_rsp_valid;
  assign bus.rsp_rdata   = r_rdata;
  assign bus.rsp_err     = r_err;
  assign bus.rsp_timeout = r_timeout;
  assign bus.psel        = w_psel;
  assign bus.penable     = w_penable;
  assign bus.paddr       = r_addr;
  assign bus.pwrite      = r_write;
  assign bus.pwdata      = r_wdata;
  assign bus.pstrb       = r_strb;
endmodule
`default_nettype wire
